// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard sequencer state encodings and the opcodes it decodes.
package pipeline_pkg;

  typedef enum logic [1:0] {
    HS_IDLE     = 2'b00,
    HS_RUN      = 2'b01,
    HS_LU_STALL = 2'b10,
    HS_MEM_WAIT = 2'b11
  } hs_state_e;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BUBBLE = 6'b111111;

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load in ID/EX and the instruction in ID.
module load_use_detect (
  input  logic [5:0] op_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  output logic       hazard_o
);
  import pipeline_pkg::*;

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit   = (idex_rt_i == rs_i) && (op_i != OP_J);
    rt_hit   = (idex_rt_i == rt_i) && reads_rt(op_i);
    // $0 is hard-wired, so a load into it never creates a dependency.
    hazard_o = idex_memread_i && (idex_rt_i != 5'd0) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, memory wait freezes, ID flushes.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_sequencer #(
  parameter int unsigned LU_STALL_CYC = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       op_i,
  input  logic [4:0]       rs_i,
  input  logic [4:0]       rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             bubble_o,
  output logic             pipe_en_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  import pipeline_pkg::*;

  localparam int unsigned LuW = (LU_STALL_CYC > 2) ? $clog2(LU_STALL_CYC) : 1;

  hs_state_e      state_q, state_d;
  hs_state_e      ret_q, ret_d;
  hs_state_e      eff_state;
  logic [LuW-1:0] lu_cnt_q, lu_cnt_d;
  logic           hazard;

  load_use_detect u_load_use_detect (
    .op_i           (op_i),
    .rs_i           (rs_i),
    .rt_i           (rt_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .hazard_o       (hazard)
  );

  always_comb begin
    // When memory releases, the saved state acts in the same cycle so no extra freeze is added.
    eff_state    = ((state_q == HS_MEM_WAIT) && !mem_busy_i) ? ret_q : state_q;
    state_d      = state_q;
    ret_d        = ret_q;
    lu_cnt_d     = lu_cnt_q;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    bubble_o     = 1'b1;
    pipe_en_o    = 1'b0;
    case (eff_state)
      HS_IDLE: begin
        if (start_i) state_d = HS_RUN;
      end
      HS_MEM_WAIT: begin
        bubble_o = 1'b0;
      end
      default: begin
        state_d = eff_state;
        if (mem_busy_i) begin
          bubble_o = 1'b0;
          state_d  = HS_MEM_WAIT;
          ret_d    = eff_state;
        end else if (eff_state == HS_LU_STALL) begin
          pipe_en_o = 1'b1;
          lu_cnt_d  = lu_cnt_q - 1'b1;
          if (lu_cnt_q <= LuW'(1)) state_d = HS_RUN;
        end else if (hazard) begin
          pipe_en_o = 1'b1;
          if (LU_STALL_CYC > 1) begin
            state_d  = HS_LU_STALL;
            lu_cnt_d = LuW'(LU_STALL_CYC - 1);
          end
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          pipe_en_o    = 1'b1;
          bubble_o     = 1'b0;
          ifid_flush_o = branch_taken_i | jump_i;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= HS_IDLE;
      ret_q    <= HS_IDLE;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((state_q != HS_IDLE) && !pc_write_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (ifid_flush_o && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: two instances (1 and 3 bubble cycles) share stimulus.
module tb_hazard_sequencer;
  import pipeline_pkg::*;

  localparam int unsigned CntW1 = 4;
  localparam int unsigned CntW3 = 16;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic [5:0] op_i = '0;
  logic [4:0] rs_i = '0;
  logic [4:0] rt_i = '0;
  logic       idex_memread_i = 1'b0;
  logic [4:0] idex_rt_i = '0;
  logic       branch_taken_i = 1'b0;
  logic       jump_i = 1'b0;
  logic       mem_busy_i = 1'b0;

  logic             pcw1, ifw1, fl1, bub1, pen1;
  logic             pcw3, ifw3, fl3, bub3, pen3;
  logic [CntW1-1:0] sc1, fc1;
  logic [CntW3-1:0] sc3, fc3;

  always #5 clk_i = ~clk_i;

  hazard_sequencer #(.LU_STALL_CYC(1), .CNT_W(CntW1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i),
    .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i), .branch_taken_i(branch_taken_i),
    .jump_i(jump_i), .mem_busy_i(mem_busy_i), .pc_write_o(pcw1), .ifid_write_o(ifw1),
    .ifid_flush_o(fl1), .bubble_o(bub1), .pipe_en_o(pen1), .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  hazard_sequencer #(.LU_STALL_CYC(3), .CNT_W(CntW3)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i),
    .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i), .branch_taken_i(branch_taken_i),
    .jump_i(jump_i), .mem_busy_i(mem_busy_i), .pc_write_o(pcw3), .ifid_write_o(ifw3),
    .ifid_flush_o(fl3), .bubble_o(bub3), .pipe_en_o(pen3), .stall_cnt_o(sc3), .flush_cnt_o(fc3)
  );

  // Output vector order: {pc_write, ifid_write, ifid_flush, bubble, pipe_en}
  localparam logic [4:0] OutReset  = 5'b00010;
  localparam logic [4:0] OutFreeze = 5'b00000;
  localparam logic [4:0] OutBubble = 5'b00011;
  localparam logic [4:0] OutFlush  = 5'b11101;
  localparam logic [4:0] OutNormal = 5'b11001;

  typedef struct {
    logic [4:0] o1;
    logic [4:0] o3;
    int         sc1, fc1, sc3, fc3;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: started flag plus a count of bubbles still owed.
  bit running[2] = '{0, 0};
  int rem[2]    = '{0, 0};
  int scnt[2]   = '{0, 0};
  int fcnt[2]   = '{0, 0};
  int lu[2]     = '{1, 3};
  int cmax[2]   = '{(1 << CntW1) - 1, (1 << CntW3) - 1};

  function automatic bit model_hazard();
    bit rt_src;
    if (!idex_memread_i || idex_rt_i == 5'd0) return 1'b0;
    rt_src = (op_i == OP_RTYPE) || (op_i == OP_BEQ) || (op_i == OP_SW);
    return ((idex_rt_i == rs_i) && (op_i != OP_J)) || ((idex_rt_i == rt_i) && rt_src);
  endfunction

  task automatic model_step(input int k, output logic [4:0] o, output int sc, output int fc);
    bit was_run;
    if (rst_i) begin
      running[k] = 0; rem[k] = 0; scnt[k] = 0; fcnt[k] = 0;
    end
    sc = scnt[k];
    fc = fcnt[k];
    was_run = running[k] && !rst_i;
    o = OutReset;
    if (rst_i) begin
      o = OutReset;
    end else if (!running[k]) begin
      running[k] = start_i;
    end else if (mem_busy_i) begin
      o = OutFreeze;
    end else if (rem[k] > 0) begin
      o = OutBubble;
      rem[k]--;
    end else if (model_hazard()) begin
      o = OutBubble;
      rem[k] = lu[k] - 1;
    end else if (branch_taken_i || jump_i) begin
      o = OutFlush;
    end else begin
      o = OutNormal;
    end
    if (was_run && !o[4] && scnt[k] < cmax[k]) scnt[k]++;
    if (o[2] && fcnt[k] < cmax[k]) fcnt[k]++;
  endtask

  task automatic chk_bits(input string nm, input logic [4:0] got, input logic [4:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, got, want);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, want);
    end
  endtask

  task automatic cyc(input bit r, input bit st, input bit mr, input logic [4:0] irt,
                     input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input bit br, input bit j, input bit bz);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i = r; start_i = st; idex_memread_i = mr; idex_rt_i = irt; op_i = op;
    rs_i = rs; rt_i = rt; branch_taken_i = br; jump_i = j; mem_busy_i = bz;
    model_step(0, e.o1, e.sc1, e.fc1);
    model_step(1, e.o3, e.sc3, e.fc3);
`ifndef HAZARD_PERF_CNT_EN
    e.sc1 = 0; e.fc1 = 0; e.sc3 = 0; e.fc3 = 0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 5'd0, OP_RTYPE, 5'd0, 5'd0, 0, 0, 0);
  endtask

  // lw $2 in EX, add $3,$2,$4 in ID
  task automatic load_use();
    cyc(0, 0, 1, 5'd2, OP_RTYPE, 5'd2, 5'd4, 0, 0, 0);
  endtask

  task automatic rst_pulse();
    cyc(1, 0, 0, 5'd0, OP_RTYPE, 5'd0, 5'd0, 0, 0, 0);
    #1;
    chk_bits("async_rst_out1", {pcw1, ifw1, fl1, bub1, pen1}, OutReset);
    chk_bits("async_rst_out3", {pcw3, ifw3, fl3, bub3, pen3}, OutReset);
    chk_int("async_rst_stall_cnt3", int'(sc3), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_bits("outputs_lu1", {pcw1, ifw1, fl1, bub1, pen1}, e.o1);
        chk_bits("outputs_lu3", {pcw3, ifw3, fl3, bub3, pen3}, e.o3);
        chk_int("stall_cnt_lu1", int'(sc1), e.sc1);
        chk_int("flush_cnt_lu1", int'(fc1), e.fc1);
        chk_int("stall_cnt_lu3", int'(sc3), e.sc3);
        chk_int("flush_cnt_lu3", int'(fc3), e.fc3);
      end
    end
  end

  initial begin : driver
    logic [5:0] ops[6];
    ops = '{OP_RTYPE, OP_BEQ, OP_SW, OP_J, 6'b100011, 6'b001000};

    cyc(1, 0, 0, 5'd0, OP_RTYPE, 5'd0, 5'd0, 0, 0, 0);
    cyc(1, 0, 0, 5'd0, OP_RTYPE, 5'd0, 5'd0, 0, 0, 0);
    nop(2);
    cyc(0, 1, 0, 5'd0, OP_RTYPE, 5'd0, 5'd0, 0, 0, 0);
    nop(2);
    load_use();
    nop(4);
    cyc(0, 0, 1, 5'd3, OP_BEQ, 5'd1, 5'd3, 0, 0, 0);
    nop(3);
    cyc(0, 0, 1, 5'd0, OP_RTYPE, 5'd0, 5'd0, 0, 0, 0);
    cyc(0, 0, 1, 5'd5, OP_J, 5'd1, 5'd5, 0, 1, 0);
    nop(1);
    cyc(0, 0, 0, 5'd0, OP_BEQ, 5'd1, 5'd2, 1, 0, 0);
    nop(2);
    cyc(0, 0, 1, 5'd2, OP_BEQ, 5'd2, 5'd0, 1, 0, 0);
    nop(3);
    load_use();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 5'd0, OP_RTYPE, 5'd0, 5'd0, 0, 0, 1);
    nop(4);
    load_use();
    nop(1);
    rst_pulse();
    nop(2);
    cyc(0, 1, 0, 5'd0, OP_RTYPE, 5'd0, 5'd0, 0, 0, 0);
    load_use();
    nop(4);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(9) < 3), $urandom_range(1),
          5'($urandom_range(3)), ops[$urandom_range(5)], 5'($urandom_range(3)),
          5'($urandom_range(3)), ($urandom_range(19) < 3), ($urandom_range(19) < 2),
          ($urandom_range(19) < 3));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_i);
    @(posedge clk_i);
    chk_int("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
